// File: rtl/keystream_diffuser_pkg.sv
// Shared types and defaults for the keystream diffuser: key-byte width, FIFO depth,
// chaining seed and FSM state encodings.
package keystream_diffuser_pkg;

  localparam int unsigned KeyW = 8;
  localparam int unsigned FifoDepthDefault = 8;
  localparam logic [KeyW-1:0] IvDefault = 8'hA5;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

endpackage

// File: rtl/keystream_diffuser_key_fifo.sv
// Key-byte FIFO: writes three bytes per push, reads one per pop, circular buffer.
// DEPTH must be a power of two so the pointers wrap for free.
module keystream_diffuser_key_fifo
  import keystream_diffuser_pkg::*;
#(
  parameter int unsigned DEPTH = FifoDepthDefault,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [KeyW-1:0] din0,
  input  logic [KeyW-1:0] din1,
  input  logic [KeyW-1:0] din2,
  input  logic            pop,
  output logic [KeyW-1:0] head,
  output logic [CntW-1:0] count
);

  logic [KeyW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]                <= din0;
      mem_q[wr_ptr_q + PtrW'(1)]     <= din1;
      mem_q[wr_ptr_q + PtrW'(2)]     <= din2;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push) count_d = count_d + CntW'(3);
    if (pop)  count_d = count_d - CntW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(3);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/keystream_diffuser.sv
// Chained XOR/add pixel cipher fed by a key-byte FIFO filled from extractor triplets.
// Optional decrypt mode is built when KEYSTREAM_DIFFUSER_DECRYPT_EN is defined.
module keystream_diffuser
  import keystream_diffuser_pkg::*;
#(
  parameter int unsigned     FIFO_DEPTH = FifoDepthDefault,
  parameter int unsigned     NPIX_W     = 20,
  parameter logic [KeyW-1:0] IV         = IvDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NPIX_W-1:0] num_pixels,
`ifdef KEYSTREAM_DIFFUSER_DECRYPT_EN
  input  logic              decrypt,
`endif
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [22:0]       ex1,
  input  logic [22:0]       ex2,
  input  logic [22:0]       ex3,
  input  logic              pix_in_valid,
  output logic              pix_in_ready,
  input  logic [7:0]        pix_in,
  output logic              pix_out_valid,
  input  logic              pix_out_ready,
  output logic [7:0]        pix_out,
  output logic              pix_out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [1:0]        state_q, state_d;
  logic [NPIX_W-1:0] remaining_q, remaining_d;
  logic [7:0]        chain_q, chain_d;
  logic [7:0]        pix_out_q, pix_out_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;

  logic [KeyW-1:0]   key_head;
  logic [CntW-1:0]   key_count;
  logic              fifo_push, accept;
  logic [7:0]        cipher_out, chain_next;

  // Only the low key byte of each extractor word feeds the keystream.
  logic unused_ex;
  assign unused_ex = ^{ex1[22:KeyW], ex2[22:KeyW], ex3[22:KeyW]};

  assign ex_ready     = (key_count <= CntW'(FIFO_DEPTH - 3));
  assign fifo_push    = ex_valid && ex_ready;
  assign pix_in_ready = (state_q == StRun) && (key_count != '0) && (!valid_q || pix_out_ready);
  assign accept       = pix_in_valid && pix_in_ready;

  keystream_diffuser_key_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_key_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din0  (ex1[KeyW-1:0]),
    .din1  (ex2[KeyW-1:0]),
    .din2  (ex3[KeyW-1:0]),
    .pop   (accept),
    .head  (key_head),
    .count (key_count)
  );

`ifdef KEYSTREAM_DIFFUSER_DECRYPT_EN
  logic decrypt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decrypt_q <= 1'b0;
    end else if (state_q == StIdle && start) begin
      decrypt_q <= decrypt;
    end
  end

  // Decrypt chains on the received ciphertext so both directions share one chain.
  always_comb begin
    if (decrypt_q) begin
      cipher_out = (pix_in - chain_q) ^ key_head;
      chain_next = pix_in;
    end else begin
      cipher_out = (pix_in ^ key_head) + chain_q;
      chain_next = cipher_out;
    end
  end
`else
  always_comb begin
    cipher_out = (pix_in ^ key_head) + chain_q;
    chain_next = cipher_out;
  end
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    chain_d     = chain_q;
    pix_out_d   = pix_out_q;
    valid_d     = valid_q;
    last_d      = last_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          remaining_d = (num_pixels == '0) ? NPIX_W'(1) : num_pixels;
          chain_d     = IV;
          state_d     = StRun;
        end
      end
      StRun: begin
        if (accept) begin
          pix_out_d   = cipher_out;
          valid_d     = 1'b1;
          last_d      = (remaining_q == NPIX_W'(1));
          chain_d     = chain_next;
          remaining_d = remaining_q - NPIX_W'(1);
          if (remaining_q == NPIX_W'(1)) state_d = StFlush;
        end else if (valid_q && pix_out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      StFlush: begin
        if (valid_q && pix_out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      chain_q     <= IV;
      pix_out_q   <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      chain_q     <= chain_d;
      pix_out_q   <= pix_out_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

  assign pix_out       = pix_out_q;
  assign pix_out_valid = valid_q;
  assign pix_out_last  = last_q;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;

endmodule
